// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the banked SRAM array.
package sram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 2;

    function automatic int row_bits_f(input int height);
        return $clog2(height);
    endfunction

    // A single bank still gets one address bit so the bank field never has zero width.
    function automatic int bank_bits_f(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic bit read_latency_ok_f(input int lat);
        return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/sram_bank.sv
// One HEIGHT x DATA_WIDTH byte-masked bank with a registered read port.
// Per-byte even parity is stored when SRAM_PARITY_EN is defined.
module sram_bank
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int HEIGHT     = 128,
    parameter int ROW_BITS   = row_bits_f(HEIGHT)
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] wmask_i,
    input  logic [ROW_BITS-1:0]     row_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
`ifdef SRAM_PARITY_EN
    input  logic                    inject_i,
    output logic                    perr_o,
`endif
    input  logic                    rd_en_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [HEIGHT];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane writes and the registered read share the single row address.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wmask_i[i]) begin
                    mem_q[row_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[row_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef SRAM_PARITY_EN
    function automatic logic [NB-1:0] lane_parity(input logic [DATA_WIDTH-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            p[i] = ^w[i*8 +: 8];
        end
        return p;
    endfunction

    logic [NB-1:0] par_q [HEIGHT];
    logic [NB-1:0] rpar_q;
    logic [NB-1:0] wpar_s;

    // Injection flips only byte 0 so a single-lane fault can be provoked on demand.
    assign wpar_s = lane_parity(wdata_i) ^ NB'(inject_i);

    // Parity bits follow their lane's write enable and are read with the data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wmask_i[i]) begin
                    par_q[row_i][i] <= wpar_s[i];
                end
            end
        end
        if (rd_en_i) begin
            rpar_q <= par_q[row_i];
        end
    end

    assign perr_o = |(rpar_q ^ lane_parity(rdata_q));
`endif

endmodule

// File: rtl/sram_bank_array.sv
// Multi-bank single-port SRAM with a row-sweep clear engine and 1- or 2-cycle reads.
// Optional per-byte parity and error injection: define SRAM_PARITY_EN.
module sram_bank_array
    import sram_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    HEIGHT       = 128,
    parameter int                    NUM_BANKS    = 4,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0,
    localparam int ROW_BITS    = row_bits_f(HEIGHT),
    localparam int BANK_BITS   = bank_bits_f(NUM_BANKS),
    localparam int ADDR_BITS   = ROW_BITS + BANK_BITS,
    localparam int WMASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_BITS-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic                   clear_start,
    output logic                   clear_busy,
    output logic                   clear_done,
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  rsp_data
`ifdef SRAM_PARITY_EN
   ,input  logic                   err_inject,
    output logic                   rsp_parity_err
`endif
);

    localparam int BANK_SLOTS = 1 << BANK_BITS;
    localparam bit TWO_STAGE  = read_latency_ok_f(READ_LATENCY) && (READ_LATENCY == 2);

    state_e                 state_q, state_d;
    logic [ROW_BITS-1:0]    cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   v1_q;
    logic [BANK_BITS-1:0]   bank_q;
    logic [DATA_WIDTH-1:0]  out_q;

    logic                   accept_s, rd_accept_s, wr_accept_s, clear_we_s;
    logic [BANK_BITS-1:0]   bank_sel_s;
    logic [ROW_BITS-1:0]    row_s;
    logic [WMASK_WIDTH-1:0] wmask_s;
    logic [DATA_WIDTH-1:0]  wdata_s;
    logic [DATA_WIDTH-1:0]  bank_rdata_s [BANK_SLOTS];

    assign req_ready   = (state_q == IDLE) && !clear_start && !rst;
    assign accept_s    = req_valid && req_ready;
    assign rd_accept_s = accept_s && !req_write;
    assign wr_accept_s = accept_s && req_write;
    // Gating with rst keeps the row under the sweep untouched when reset lands mid-clear.
    assign clear_we_s  = (state_q == CLEAR) && !rst;
    assign bank_sel_s  = req_addr[ADDR_BITS-1 -: BANK_BITS];
    assign clear_busy  = (state_q == CLEAR);
    assign clear_done  = done_q;

    // The single port is owned by the clear engine while sweeping, else by requests.
    always_comb begin
        row_s   = req_addr[ROW_BITS-1:0];
        wmask_s = req_wmask;
        wdata_s = req_wdata;
        if (clear_we_s) begin
            row_s   = cnt_q;
            wmask_s = '1;
            wdata_s = CLEAR_VALUE;
        end else begin
            row_s   = req_addr[ROW_BITS-1:0];
        end
    end

    // Clear FSM next-state: sweep rows 0..HEIGHT-1, pulse done on return to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (cnt_q == ROW_BITS'(HEIGHT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + ROW_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Response stage 1 tracks which bank holds the read; out_q keeps the last response.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            bank_q <= '0;
            out_q  <= '0;
        end else begin
            v1_q <= rd_accept_s;
            if (rd_accept_s) begin
                bank_q <= bank_sel_s;
            end
            if (v1_q) begin
                out_q <= bank_rdata_s[bank_q];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic bank_perr_s [BANK_SLOTS];
    logic perr_q;

    // Parity flag shadows the data path so it lines up with rsp_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (v1_q) begin
            perr_q <= bank_perr_s[bank_q];
        end
    end
`endif

    for (genvar b = 0; b < BANK_SLOTS; b++) begin : g_slot
        if (b < NUM_BANKS) begin : g_bank
            logic sel_s;
            assign sel_s = (bank_sel_s == BANK_BITS'(b));
            sram_bank #(
                .DATA_WIDTH (DATA_WIDTH),
                .HEIGHT     (HEIGHT),
                .ROW_BITS   (ROW_BITS)
            ) u_bank (
                .clk      (clk),
                .we_i     (clear_we_s || (wr_accept_s && sel_s)),
                .wmask_i  (wmask_s),
                .row_i    (row_s),
                .wdata_i  (wdata_s),
`ifdef SRAM_PARITY_EN
                .inject_i (err_inject && !clear_we_s),
                .perr_o   (bank_perr_s[b]),
`endif
                .rd_en_i  (rd_accept_s && sel_s),
                .rdata_o  (bank_rdata_s[b])
            );
        end else begin : g_pad
            assign bank_rdata_s[b] = '0;
`ifdef SRAM_PARITY_EN
            assign bank_perr_s[b] = 1'b0;
`endif
        end
    end

    if (TWO_STAGE) begin : g_lat2
        logic v2_q;

        // Extra output register stage for latency 2.
        always_ff @(posedge clk) begin
            if (rst) begin
                v2_q <= 1'b0;
            end else begin
                v2_q <= v1_q;
            end
        end

        assign rsp_valid = v2_q;
        assign rsp_data  = out_q;
`ifdef SRAM_PARITY_EN
        assign rsp_parity_err = perr_q;
`endif
    end else begin : g_lat1
        assign rsp_valid = v1_q;
        assign rsp_data  = v1_q ? bank_rdata_s[bank_q] : out_q;
`ifdef SRAM_PARITY_EN
        assign rsp_parity_err = v1_q ? bank_perr_s[bank_q] : perr_q;
`endif
    end

endmodule

// File: tb/tb_sram_bank_array.sv
// Scoreboard bench driving a latency-1 and a latency-2 instance with identical stimulus.
module tb_sram_bank_array;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_write, clear_start;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        ready1, ready2, busy1, busy2, done1, done2, rv1, rv2;
    logic [31:0] rd1, rd2;
`ifdef SRAM_PARITY_EN
    logic        err_inject, pe1, pe2, exp_perr;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
`ifdef SRAM_PARITY_EN
        logic        perr;
`endif
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   busy_cnt1, busy_cnt2, done_cnt1, done_cnt2;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sram_bank_array #(.READ_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .clear_start(clear_start), .clear_busy(busy1),
        .clear_done(done1), .rsp_valid(rv1), .rsp_data(rd1)
`ifdef SRAM_PARITY_EN
       ,.err_inject(err_inject), .rsp_parity_err(pe1)
`endif
    );

    sram_bank_array #(.READ_LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .clear_start(clear_start), .clear_busy(busy2),
        .clear_done(done2), .rsp_valid(rv2), .rsp_data(rd2)
`ifdef SRAM_PARITY_EN
       ,.err_inject(err_inject), .rsp_parity_err(pe2)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fill_val(input int a, input logic [7:0] seed);
        return {seed, 8'(a), ~8'(a >> 1), 8'(a) ^ seed};
    endfunction

    task automatic do_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
`ifdef SRAM_PARITY_EN
        err_inject = 1'b0;
`endif
    endtask

    task automatic do_read(input logic [8:0] a, input logic [31:0] d, input bit to2);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wmask = 4'h0;
        e.data = d;
        e.cyc  = cyc + 1;
`ifdef SRAM_PARITY_EN
        err_inject = 1'b0;
        e.perr = exp_perr;
`endif
        q1.push_back(e);
        if (to2) begin
            e.cyc = cyc + 2;
            q2.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    // Latency-1 response monitor.
    always @(negedge clk) begin
        if (rv1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("lat1_unexpected_rsp", 64'(rv1), 64'd0);
            end else begin
                e1 = q1.pop_front();
                chk("lat1_rsp_data", 64'(rd1), 64'(e1.data));
                chk("lat1_rsp_cycle", 64'(cyc), 64'(e1.cyc));
`ifdef SRAM_PARITY_EN
                chk("lat1_parity_err", 64'(pe1), 64'(e1.perr));
`endif
            end
        end
    end

    // Latency-2 response monitor.
    always @(negedge clk) begin
        if (rv2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("lat2_unexpected_rsp", 64'(rv2), 64'd0);
            end else begin
                e2 = q2.pop_front();
                chk("lat2_rsp_data", 64'(rd2), 64'(e2.data));
                chk("lat2_rsp_cycle", 64'(cyc), 64'(e2.cyc));
`ifdef SRAM_PARITY_EN
                chk("lat2_parity_err", 64'(pe2), 64'(e2.perr));
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 9'h0;
        req_wdata = 32'h0; req_wmask = 4'h0; clear_start = 1'b0;
`ifdef SRAM_PARITY_EN
        err_inject = 1'b0; exp_perr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid1", 64'(rv1), 64'd0);
        chk("reset_rsp_valid2", 64'(rv2), 64'd0);
        chk("reset_rsp_data1", 64'(rd1), 64'd0);
        chk("reset_rsp_data2", 64'(rd2), 64'd0);
        chk("reset_busy", 64'({busy1, busy2}), 64'd0);
        chk("reset_done", 64'({done1, done2}), 64'd0);
        chk("ready_in_reset", 64'({ready1, ready2}), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 64'({ready1, ready2}), 64'd3);

        // Full write then read, then hold of rsp_data while idle.
        do_write(9'h085, 32'hDEADBEEF, 4'hF);
        do_read(9'h085, 32'hDEADBEEF, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        chk("idle_valid", 64'({rv1, rv2}), 64'd0);
        chk("hold_data1", 64'(rd1), 64'hDEADBEEF);
        chk("hold_data2", 64'(rd2), 64'hDEADBEEF);

        // Byte mask merge and zero mask.
        do_write(9'h1FF, 32'hFFFFFFFF, 4'hF);
        do_write(9'h1FF, 32'h12345678, 4'b0101);
        do_read(9'h1FF, 32'hFF34FF78, 1'b1);
        do_write(9'h085, 32'h00000000, 4'h0);
        do_read(9'h085, 32'hDEADBEEF, 1'b1);

        // Same row in every bank, read back-to-back.
        for (int b = 0; b < 4; b++) do_write(9'(b * 128), 32'hB0000000 | 32'(b), 4'hF);
        for (int b = 0; b < 4; b++) do_read(9'(b * 128), 32'hB0000000 | 32'(b), 1'b1);
        idle();
        repeat (4) @(negedge clk);

        // Full sweep with a pre-clear read in flight and a colliding request.
        for (int a = 0; a < 512; a++) do_write(9'(a), fill_val(a, 8'h11), 4'hF);
        do_read(9'h123, fill_val(32'h123, 8'h11), 1'b1);
        @(negedge clk);
        clear_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h000;
        #1;
        chk("clear_blocks_req", 64'({ready1, ready2}), 64'd0);
        busy_cnt1 = 0; busy_cnt2 = 0; done_cnt1 = 0; done_cnt2 = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            clear_start = (i == 60);
            if (busy1) busy_cnt1++;
            if (busy2) busy_cnt2++;
            if (done1) done_cnt1++;
            if (done2) done_cnt2++;
        end
        clear_start = 1'b0;
        chk("busy_cycles1", 64'(busy_cnt1), 64'd128);
        chk("busy_cycles2", 64'(busy_cnt2), 64'd128);
        chk("done_pulses1", 64'(done_cnt1), 64'd1);
        chk("done_pulses2", 64'(done_cnt2), 64'd1);
        for (int a = 0; a < 512; a++) do_read(9'(a), 32'h0, 1'b1);
        idle();
        repeat (4) @(negedge clk);

        // Reset after 40 swept rows.
        for (int a = 0; a < 512; a++) do_write(9'(a), fill_val(a, 8'h22), 4'hF);
        idle();
        @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        chk("sweep_started", 64'({busy1, busy2}), 64'd3);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'({busy1, busy2}), 64'd0);
        done_cnt1 = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done1 || done2) done_cnt1++;
        end
        chk("abort_no_done", 64'(done_cnt1), 64'd0);
        for (int a = 0; a < 512; a++)
            do_read(9'(a), ((a % 128) < 40) ? 32'h0 : fill_val(a, 8'h22), 1'b1);
        idle();
        repeat (4) @(negedge clk);

        // Reset while a read is in flight: only the latency-1 response escapes.
        do_read(9'h0C0, fill_val(32'h0C0, 8'h22), 1'b0);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

`ifdef SRAM_PARITY_EN
        do_write(9'h010, 32'h000000A5, 4'hF);
        err_inject = 1'b1;
        exp_perr = 1'b1;
        do_read(9'h010, 32'h000000A5, 1'b1);
        exp_perr = 1'b0;
        do_write(9'h011, 32'h12345678, 4'hF);
        do_read(9'h011, 32'h12345678, 1'b1);
        do_write(9'h010, 32'h0000005A, 4'hF);
        do_read(9'h010, 32'h0000005A, 1'b1);
        idle();
        repeat (4) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        chk("lat1_queue_drained", 64'(q1.size()), 64'd0);
        chk("lat2_queue_drained", 64'(q2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_bank_array.md
Name: sram_bank_array

Overview:
Parametrised multi-bank, single-port synchronous SRAM array with byte-masked writes, a valid/ready request port and a fixed-latency read response. It is the successor to the single-bank memory model. It adds a selectable read latency and a hardware clear engine that sweeps every row to a constant. It sits between the RL accelerator controller and the weight/Q-table storage. It maps to block RAM.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- HEIGHT, 128, rows per bank; power of 2.
- NUM_BANKS, 4, number of banks; power of 2.
- READ_LATENCY, 1, read latency in cycles from acceptance to rsp_valid; legal values 1 or 2.
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written by the clear engine.
- Derived, not overridable: ROW_BITS = $clog2(HEIGHT); BANK_BITS = max(1, $clog2(NUM_BANKS)); ADDR_BITS = ROW_BITS + BANK_BITS; WMASK_WIDTH = DATA_WIDTH/8.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst, input, 1, synchronous reset, active-high.
- req_valid, input, 1, request present.
- req_ready, output, 1, request accepted when req_valid and req_ready are both high.
- req_write, input, 1, 1 = write, 0 = read.
- req_addr, input, ADDR_BITS, address; bank = upper BANK_BITS, row = lower ROW_BITS.
- req_wdata, input, DATA_WIDTH, write data.
- req_wmask, input, WMASK_WIDTH, byte-lane write enables.
- clear_start, input, 1, start the clear sweep (ignored unless IDLE).
- clear_busy, output, 1, high while a sweep is in progress.
- clear_done, output, 1, one-cycle pulse when a sweep completes.
- rsp_valid, output, 1, read data valid.
- rsp_data, output, DATA_WIDTH, read data.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE; row counter, rsp_valid, all pipeline valids, clear_busy and clear_done go to 0; rsp_data goes to 0.
  - Memory contents are not altered by reset.
- FSM:
  - IDLE -> CLEAR when clear_start=1.
  - CLEAR: writes CLEAR_VALUE to row cnt of all banks in parallel each cycle, then cnt++.
  - CLEAR -> IDLE when cnt = HEIGHT-1 is written. clear_done pulses 1 on the cycle after that last write, i.e. the first IDLE cycle. A sweep therefore takes HEIGHT cycles.
- req_ready = (state==IDLE) && !clear_start && !rst, combinational. clear_start has priority over a simultaneous request; that request is not accepted.
- clear_start during CLEAR is ignored; the sweep does not restart.
- Write acceptance: only lanes with req_wmask[i]=1 are updated; a mask of 0 means no change. A write produces no response.
- Read acceptance at edge N:
  - rsp_valid=1 for exactly one cycle after edge N+READ_LATENCY-1. Latency 1 = data visible the cycle after acceptance; latency 2 adds an output register stage.
  - Back-to-back reads produce back-to-back responses in order, throughput 1 per cycle. There is no rsp_ready; the consumer must always accept.
- rsp_data holds its last value while rsp_valid=0.
- A read accepted the cycle after a write to the same address returns the new data. The port is single, so there are no same-cycle conflicts.
- Reads already in flight when a clear starts still complete with pre-clear data.
- Reset mid-sweep: FSM returns to IDLE. Rows not yet swept keep old contents. clear_done does not pulse.
- Address wrap: no out-of-range addresses exist because all dimensions are powers of 2.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- When defined:
  - Each byte stores an even-parity bit, written together with its lane.
  - Extra output rsp_parity_err (1 bit) is valid alongside rsp_valid. It is high if any byte of the read word mismatches its stored parity, and resets to 0.
  - Extra input err_inject (1 bit): when high on an accepted write, the stored parity of byte 0 is inverted.
  - The clear engine writes correct parity.
- When undefined: no parity storage and neither port exists. Timing and all other behaviour are identical.

Decomposition:
- Package sram_pkg holds:
  - state enum {IDLE, CLEAR};
  - localparam functions for ROW_BITS/BANK_BITS;
  - the READ_LATENCY legality check constant.
- Sub-module sram_bank: one HEIGHT x DATA_WIDTH byte-masked bank, plus parity bits under the macro, with a registered 1-cycle read. It is instantiated NUM_BANKS times in a generate loop. The top level holds the FSM, bank decode, response mux and latency pipeline.

Test Plan:
1. Write 0xDEADBEEF to addr 0x085 (mask 4'hF), then read 0x085 with READ_LATENCY=1 -> rsp_valid one cycle after acceptance, rsp_data=0xDEADBEEF. Same test with READ_LATENCY=2 -> response one cycle later.
2. Write 0xFFFFFFFF to addr 0x1FF, then write 0x12345678 with mask 4'b0101, then read -> 0xFF34FF78.
3. Reads to addresses 0x000, 0x080, 0x100, 0x180 on 4 consecutive cycles -> 4 consecutive rsp_valid cycles, data in order, each from the correct bank.
4. Fill the array, then assert clear_start together with req_valid:
   - request is not accepted;
   - clear_busy is high for 128 cycles and clear_done pulses once;
   - every address then reads 0.
5. Assert rst at cycle 40 of a sweep -> state IDLE, no clear_done, rows 0-39 read 0, rows >= 40 read old data. Reset with a read in flight -> that rsp_valid is suppressed.
6. With SRAM_PARITY_EN: write with err_inject=1, then read -> rsp_parity_err=1. A normal write then read -> rsp_parity_err=0.
